// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported memory between the instruction-fetch and data ports.
// Serialises accesses over a req/ack handshake, returns per-port stalls, and aborts on ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_stall,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              data_stall,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_D_BURST);
  localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              dreq;
  logic              grant_d, grant_i;
  logic              d_ack, i_ack;
  logic              tmo_hit;
  logic [3:0]        burst_cnt;
  logic [7:0]        tmo_cnt;
  logic [DATA_W-1:0] inst_q, data_q;

  assign dreq    = mem_ren | mem_wen;
  assign d_ack   = (state == D_ACC) & ram_ack;
  assign i_ack   = (state == I_ACC) & ram_ack;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    unique case (state)
      IDLE: begin
        // Data wins ties (older instruction) unless the fetch has waited out a full burst.
        if (dreq && !(inst_ren && burst_cnt == BURST_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = D_ACC;
        end else if (inst_ren) begin
          grant_i   = 1'b1;
          state_nxt = I_ACC;
        end
      end
      D_ACC, I_ACC: begin
        if (ram_ack || tmo_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the read-data holding registers are reset too, so mem_din/inst_data are 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      inst_q    <= '0;
      data_q    <= '0;
      burst_cnt <= '0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if (grant_d || grant_i) begin
        ram_cs    <= 1'b1;
        ram_we    <= grant_d & mem_wen;
        ram_addr  <= grant_d ? mem_addr : inst_addr;
        ram_wdata <= mem_dout;
        tmo_cnt   <= '0;
      end else if (state != IDLE) begin
        if (ram_ack) begin
          ram_cs <= 1'b0;
          if (state == I_ACC)  inst_q <= ram_rdata;
          else if (!ram_we)    data_q <= ram_rdata;
        end else if (tmo_hit) begin
          ram_cs <= 1'b0;
          err    <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end

      if (grant_d && inst_ren) begin
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
      end else if (grant_i || (state == IDLE && !inst_ren)) begin
        burst_cnt <= '0;
      end
    end
  end

  // Stalls are forced low while reset is held so the pipeline is released immediately.
  assign inst_stall = rst_n & inst_ren & ~i_ack;
  assign data_stall = rst_n & dreq & ~d_ack;

  // Bypass only read completions; a write ack leaves the last loaded word visible.
  assign inst_data = i_ack ? ram_rdata : inst_q;
  assign mem_din   = (d_ack & ~ram_we) ? ram_rdata : data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_ren, mem_ren, mem_wen;
  logic [AW-1:0] inst_addr, mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] inst_data, mem_din;
  logic          inst_stall, data_stall;
  logic          ram_cs, ram_we, err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  wire  [DW-1:0] ram_rdata;
  wire           ram_ack;

  logic          resp_ack = 1'b0, inj_ack = 1'b0;
  logic [DW-1:0] resp_rdata = '0;
  assign ram_ack   = resp_ack | inj_ack;
  assign ram_rdata = inj_ack ? 32'hBAD0_BAD0 : resp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  bit chk_en = 1'b0;
  bit ack_en = 1'b1;
  bit log_en = 1'b0;
  int ack_delay = 1;
  int cs_age = 0;
  logic [AW-1:0] grants[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .data_stall(data_stall),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2408_000A : ((a ^ 32'h1357_0000) + 32'h11);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks ack_delay cycles after the first ram_cs cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      resp_ack = 1'b0;
      if (!rst_n || !ram_cs) cs_age = 0;
      else begin
        cs_age++;
        if (cs_age == 1 && log_en) grants.push_back(ram_addr);
        if (ack_en && cs_age == ack_delay + 1) begin
          resp_ack   = 1'b1;
          resp_rdata = rd_word(ram_addr);
        end
      end
    end
  end

  // Transaction-level reference: which port owns the memory, what it captured, how long it has waited.
  int            m_busy;   // 0 none, 1 data, 2 fetch
  int            m_age, m_burst;
  logic          m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_iq, m_dq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_burst = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_iq = '0; m_dq = '0;
    end else if (m_busy == 0) begin
      if ((mem_ren || mem_wen) && !(inst_ren && m_burst == MAXB)) begin
        m_busy = 1; m_addr = mem_addr; m_we = mem_wen; m_wdata = mem_dout; m_age = 0;
        m_burst = inst_ren ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
      end else if (inst_ren) begin
        m_busy = 2; m_addr = inst_addr; m_we = 0; m_wdata = mem_dout; m_age = 0; m_burst = 0;
      end else begin
        m_burst = 0;
      end
    end else if (ram_ack) begin
      if (m_busy == 2) m_iq = ram_rdata;
      else if (!m_we)  m_dq = ram_rdata;
      m_busy = 0;
    end else begin
      m_age++;
      if (m_age == TMO) begin m_err = 1; m_busy = 0; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ram_cs", ram_cs, m_busy != 0);
      check("ram_we", ram_we, m_we);
      check("ram_addr", ram_addr, m_addr);
      check("ram_wdata", ram_wdata, m_wdata);
      check("err", err, m_err);
      check("inst_stall", inst_stall, rst_n & inst_ren & !(m_busy == 2 && ram_ack));
      check("data_stall", data_stall, rst_n & (mem_ren | mem_wen) & !(m_busy == 1 && ram_ack));
      check("inst_data", inst_data, (m_busy == 2 && ram_ack) ? ram_rdata : m_iq);
      check("mem_din", mem_din, (m_busy == 1 && ram_ack && !m_we) ? ram_rdata : m_dq);
    end
  end

  // Called at posedge+1; returns at posedge+2 of the cycle whose stall is low.
  task automatic wait_low(input bit is_inst, input int budget, output int n);
    n = 0;
    #1;
    while ((is_inst ? inst_stall : data_stall) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check(is_inst ? "fetch_done_bound" : "data_done_bound", n < budget, 1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, d_done, i_done;
    logic [DW-1:0] prev;
    logic [AW-1:0] exp_g[10];

    rst_n = 1'b1;
    inst_ren = 0; mem_ren = 0; mem_wen = 0;
    inst_addr = '0; mem_addr = '0; mem_dout = '0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", ram_cs, 0);
    check("rst_err", err, 0);
    check("rst_din", mem_din, 0);
    check("rst_idata", inst_data, 0);
    rst_n = 1'b1;
    next_cycle();

    // 1: fetch only, ack two cycles after cs
    ack_delay = 2; inst_ren = 1; inst_addr = 32'h40;
    wait_low(1, 20, n);
    check("t1_latency", n, 3);
    check("t1_inst_data_ack", inst_data, 32'h2408_000A);
    next_cycle();
    inst_ren = 0;
    #1 check("t1_inst_data_held", inst_data, 32'h2408_000A);
    next_cycle();

    // 2: load and fetch together; data first
    ack_delay = 1; mem_ren = 1; mem_addr = 32'h200; inst_ren = 1; inst_addr = 32'h44;
    d_done = -1; i_done = -1; k = 0;
    while ((d_done < 0 || i_done < 0) && k < 40) begin
      #1;
      if (d_done < 0 && !data_stall) d_done = cyc_cnt;
      if (i_done < 0 && !inst_stall) i_done = cyc_cnt;
      next_cycle();
      k++;
      if (d_done >= 0) mem_ren = 0;
      if (i_done >= 0) inst_ren = 0;
    end
    check("t2_bound", k < 40, 1);
    check("t2_order_gap", i_done - d_done, 3);
    check("t2_mem_din", mem_din, rd_word(32'h200));
    check("t2_inst_data", inst_data, rd_word(32'h44));
    next_cycle();

    // 3: store held until ack, read data untouched
    prev = mem_din;
    ack_delay = 3; mem_wen = 1; mem_addr = 32'h100; mem_dout = 32'hDEAD_BEEF;
    wait_low(0, 20, n);
    check("t3_latency", n, 4);
    check("t3_we", ram_we, 1);
    check("t3_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("t3_addr", ram_addr, 32'h100);
    check("t3_din_ack", mem_din, prev);
    next_cycle();
    mem_wen = 0; mem_dout = '0;
    #1 check("t3_din_after", mem_din, prev);
    next_cycle();

    // 4: continuous data with a waiting fetch: DDDD I DDDD I
    grants.delete();
    log_en = 1; ack_delay = 1;
    mem_ren = 1; mem_addr = 32'h300; inst_ren = 1; inst_addr = 32'h48;
    repeat (32) @(posedge clk);
    #1;
    mem_ren = 0; inst_ren = 0; log_en = 0;
    foreach (exp_g[i]) exp_g[i] = (i == 4 || i == 9) ? 32'h48 : 32'h300;
    check("t4_grant_count", grants.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grants.size(); i++) check($sformatf("t4_grant%0d", i), grants[i], exp_g[i]);
    repeat (4) next_cycle();

    // 5: no ack -> timeout after TMO cycles, late ack ignored, retry completes
    prev = mem_din;
    ack_en = 0; mem_ren = 1; mem_addr = 32'h180;
    @(posedge clk); #2;
    k = 0;
    while (ram_cs && k < 50) begin
      k++;
      @(posedge clk); #2;
    end
    check("t5_cs_cycles", k, TMO);
    check("t5_err", err, 1);
    check("t5_stall_kept", data_stall, 1);
    inj_ack = 1;
    #1;
    check("t5_late_ack_stall", data_stall, 1);
    check("t5_late_ack_din", mem_din, prev);
    next_cycle();
    inj_ack = 0; ack_en = 1;
    check("t5_retry_cs", ram_cs, 1);
    wait_low(0, 20, n);
    check("t5_retry_din", mem_din, rd_word(32'h180));
    next_cycle();
    mem_ren = 0;
    #1 check("t5_err_sticky", err, 1);
    next_cycle();

    // 6: asynchronous reset in the middle of a data access
    ack_delay = 3; mem_ren = 1; mem_addr = 32'h1C0; inst_ren = 1; inst_addr = 32'h4C;
    next_cycle();
    check("t6_cs_before", ram_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_cs_async", ram_cs, 0);
    check("t6_dstall_async", data_stall, 0);
    check("t6_istall_async", inst_stall, 0);
    check("t6_err_cleared", err, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1 check("t6_idle_after", ram_cs, 0);
    wait_low(0, 20, n);
    check("t6_latency", n, 4);
    check("t6_din", mem_din, rd_word(32'h1C0));
    next_cycle();
    mem_ren = 0;
    wait_low(1, 20, n);
    check("t6_fetch", inst_data, rd_word(32'h4C));
    next_cycle();
    inst_ren = 0;
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
